fp_cvt_i2f_seq: RTL and testbench

FP_CVT_I2F_SEQ -- requirements
Module: fp_cvt_i2f_seq

---
 rtl/fp_cvt_i2f_seq.sv | 169 ++++++++++++++++
 tb/tb_fp_cvt_i2f_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_cvt_i2f_seq.sv
// Sequential i32/ui32 -> binary32 converter (IDLE -> NORM -> ROUND -> DONE).
// Define FP_CVT_ITER_NORM_EN for a 1-bit-per-cycle normaliser instead of a single-cycle shifter.
module fp_cvt_i2f_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] data1,
  input  logic [2:0]  rm,
  input  logic        fcvt_op,
  output logic        busy,
  output logic        ready,
  output logic [31:0] result,
  output logic [4:0]  flags
);

  localparam int unsigned DW  = 32;
  localparam int unsigned EW  = 8;
  localparam int unsigned MW  = 23;
  localparam int unsigned LZW = 5;
  localparam logic [EW-1:0] EXP_TOP = EW'(158);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   mag_q, mag_d;
  logic [EW-1:0]   exp_q, exp_d;
  logic            sign_q, sign_d;
  logic [2:0]      rm_q, rm_d;
  logic            op_q, op_d;
  logic [DW-1:0]   result_q, result_d;
  logic [4:0]      flags_q, flags_d;
  logic            busy_q, ready_q;

  logic [MW-1:0]   mant;
  logic [MW:0]     mant_sum;
  logic            g, s, inc, neg, neg_in;

`ifdef FP_CVT_ITER_NORM_EN
  logic [LZW-1:0]  lz_q, lz_d;
`else
  logic [LZW-1:0]  nlz;

  // Leading-zero count of a non-zero word; highest set bit wins.
  function automatic logic [LZW-1:0] clz32(input logic [DW-1:0] v);
    logic [LZW-1:0] n;
    n = '0;
    for (int i = 0; i < DW; i++) begin
      if (v[i]) n = LZW'(31 - i);
    end
    return n;
  endfunction
`endif

  // State register and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      rm_q     <= '0;
      op_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
`ifdef FP_CVT_ITER_NORM_EN
      lz_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      rm_q     <= rm_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      busy_q   <= (state_d != IDLE);
      ready_q  <= (state_d == DONE);
`ifdef FP_CVT_ITER_NORM_EN
      lz_q     <= lz_d;
`endif
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    rm_d     = rm_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
`ifdef FP_CVT_ITER_NORM_EN
    lz_d     = lz_q;
`else
    nlz      = clz32(mag_q);
`endif

    mant   = mag_q[30:8];
    g      = mag_q[7];
    s      = |mag_q[6:0];
    neg    = sign_q & ~op_q;
    neg_in = ~fcvt_op & data1[31];

    case (rm_q)
      3'd1:    inc = 1'b0;
      3'd2:    inc = (g | s) & neg;
      3'd3:    inc = (g | s) & ~neg;
      3'd4:    inc = g;
      default: inc = g & (s | mant[0]);
    endcase
    mant_sum = {1'b0, mant} + (MW+1)'(inc);

    case (state_q)
      IDLE: begin
        if (enable) begin
          sign_d = neg_in;
          mag_d  = neg_in ? (~data1 + DW'(1)) : data1;
          rm_d   = rm;
          op_d   = fcvt_op;
          exp_d  = '0;
`ifdef FP_CVT_ITER_NORM_EN
          lz_d   = '0;
`endif
          if (data1 == '0) begin
            result_d = '0;
            flags_d  = '0;
            state_d  = DONE;
          end else begin
            state_d  = NORM;
          end
        end
      end
      NORM: begin
`ifdef FP_CVT_ITER_NORM_EN
        if (mag_q[31]) begin
          exp_d   = EXP_TOP - EW'(lz_q);
          state_d = ROUND;
        end else begin
          mag_d = {mag_q[30:0], 1'b0};
          lz_d  = lz_q + LZW'(1);
        end
`else
        mag_d   = mag_q << nlz;
        exp_d   = EXP_TOP - EW'(nlz);
        state_d = ROUND;
`endif
      end
      ROUND: begin
        // A mantissa carry-out leaves mant_sum[22:0] at zero, so only exp moves.
        result_d = {sign_q, mant_sum[MW] ? exp_q + EW'(1) : exp_q, mant_sum[MW-1:0]};
        flags_d  = {4'b0, g | s};
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy   = busy_q;
  assign ready  = ready_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_fp_cvt_i2f_seq.sv
// Directed bench for fp_cvt_i2f_seq; latency expectations follow FP_CVT_ITER_NORM_EN.
module tb_fp_cvt_i2f_seq;

`ifdef FP_CVT_ITER_NORM_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] data1 = '0;
  logic [2:0]  rm = '0;
  logic        fcvt_op = 1'b0;
  logic        busy, ready;
  logic [31:0] result;
  logic [4:0]  flags;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  r;
    logic        op;
    logic [31:0] res;
    logic [4:0]  fl;
    int          lz;
  } vec_t;

  fp_cvt_i2f_seq dut (
    .clock(clock), .reset(reset), .enable(enable), .data1(data1), .rm(rm),
    .fcvt_op(fcvt_op), .busy(busy), .ready(ready), .result(result), .flags(flags)
  );

  always #5 clock = ~clock;

  function automatic int exp_lat(input int lz);
    return ITER ? 3 + lz : 3;
  endfunction

  // Issue one request and count cycles until ready is seen (-1 on timeout).
  task automatic do_req(input logic [31:0] d, input logic [2:0] r, input logic op, output int lat);
    bit seen;
    @(negedge clock);
    data1 = d; rm = r; fcvt_op = op; enable = 1'b1;
    @(posedge clock);
    #1;
    enable = 1'b0;
    data1 = $urandom;
    rm = 3'($urandom_range(0, 7));
    fcvt_op = 1'($urandom_range(0, 1));
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clock);
      lat++;
      seen = ready;
    end
    if (!seen) lat = -1;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({busy, ready, result, flags} !== 39'd0) begin
      fails++;
      $display("FAIL reset_state: busy=%b ready=%b result=%h flags=%h, want all 0", busy, ready, result, flags);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests++;
    if ({busy, ready} !== 2'b00) begin
      fails++;
      $display("FAIL reset_idle: busy=%b ready=%b, want 0 0", busy, ready);
    end
  endtask

  task automatic test_vectors();
    vec_t v[12];
    int lat;
    logic [31:0] held;
    v[0]  = '{32'hFFFF_FFFF, 3'd0, 1'b0, 32'hBF80_0000, 5'h00, 31};
    v[1]  = '{32'hFFFF_FFFF, 3'd0, 1'b1, 32'h4F80_0000, 5'h01, 0};
    v[2]  = '{32'hFFFF_FFFF, 3'd1, 1'b1, 32'h4F7F_FFFF, 5'h01, 0};
    v[3]  = '{32'h8000_0000, 3'd2, 1'b0, 32'hCF00_0000, 5'h00, 0};
    v[4]  = '{32'h0100_0001, 3'd3, 1'b0, 32'h4B80_0001, 5'h01, 7};
    v[5]  = '{32'h0100_0001, 3'd0, 1'b0, 32'h4B80_0000, 5'h01, 7};
    v[6]  = '{32'h0100_0001, 3'd4, 1'b1, 32'h4B80_0001, 5'h01, 7};
    v[7]  = '{32'hFEFF_FFFF, 3'd2, 1'b0, 32'hCB80_0001, 5'h01, 7};
    v[8]  = '{32'hFEFF_FFFF, 3'd3, 1'b0, 32'hCB80_0000, 5'h01, 7};
    v[9]  = '{32'h0100_0001, 3'd7, 1'b0, 32'h4B80_0000, 5'h01, 7};
    v[10] = '{32'h0100_0003, 3'd0, 1'b0, 32'h4B80_0002, 5'h01, 7};
    v[11] = '{32'h0000_0001, 3'd1, 1'b1, 32'h3F80_0000, 5'h00, 31};
    for (int i = 0; i < 12; i++) begin
      do_req(v[i].d, v[i].r, v[i].op, lat);
      tests++;
      if (lat !== exp_lat(v[i].lz)) begin
        fails++;
        $display("FAIL vec%0d_latency: got %0d, want %0d", i, lat, exp_lat(v[i].lz));
      end
      tests++;
      if (result !== v[i].res) begin
        fails++;
        $display("FAIL vec%0d_result: got %h, want %h", i, result, v[i].res);
      end
      tests++;
      if (flags !== v[i].fl) begin
        fails++;
        $display("FAIL vec%0d_flags: got %h, want %h", i, flags, v[i].fl);
      end
      held = result;
      @(negedge clock);
      tests++;
      if (ready !== 1'b0 || result !== v[i].res) begin
        fails++;
        $display("FAIL vec%0d_pulse: ready=%b result=%h (held %h), want ready 0 result %h", i, ready, result, held, v[i].res);
      end
    end
  endtask

  task automatic test_zero();
    int lat;
    for (int i = 0; i < 2; i++) begin
      do_req(32'h0, 3'd3, 1'(i), lat);
      tests++;
      if (lat !== 1) begin
        fails++;
        $display("FAIL zero%0d_latency: got %0d, want 1", i, lat);
      end
      tests++;
      if (result !== 32'h0 || flags !== 5'h0) begin
        fails++;
        $display("FAIL zero%0d_value: result=%h flags=%h, want 0 0", i, result, flags);
      end
      do_req(32'h8000_0000, 3'd2, 1'b0, lat);
    end
  endtask

  task automatic test_back_to_back();
    int l, w, pulses;
    logic prev;
    l = exp_lat(7);
    w = 4 * (l + 1) - 1;
    pulses = 0;
    prev = 1'b0;
    @(negedge clock);
    data1 = 32'h0100_0001; rm = 3'd0; fcvt_op = 1'b0; enable = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= w; k++) begin
      @(negedge clock);
      if (ready) begin
        pulses++;
        tests++;
        if (prev) begin
          fails++;
          $display("FAIL b2b_pulse_width: ready high on consecutive samples at %0d", k);
        end
      end
      if (pulses > 0) begin
        tests++;
        if (result !== 32'h4B80_0000) begin
          fails++;
          $display("FAIL b2b_result_stable: got %h at sample %0d, want 4b800000", result, k);
        end
      end
      prev = ready;
    end
    enable = 1'b0;
    tests++;
    if (pulses !== 4) begin
      fails++;
      $display("FAIL b2b_pulse_count: got %0d, want 4", pulses);
    end
    repeat (3) @(negedge clock);
    tests++;
    if ({busy, ready} !== 2'b00) begin
      fails++;
      $display("FAIL b2b_idle: busy=%b ready=%b, want 0 0", busy, ready);
    end
  endtask

  task automatic test_reset_abort();
    int lat, stray;
    @(negedge clock);
    data1 = 32'hFFFF_FFFF; rm = 3'd0; fcvt_op = 1'b0; enable = 1'b1;
    @(posedge clock);
    #1;
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    tests++;
    if ({busy, ready, result, flags} !== 39'd0) begin
      fails++;
      $display("FAIL abort_reset: busy=%b ready=%b result=%h flags=%h, want all 0", busy, ready, result, flags);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    stray = 0;
    repeat (40) begin
      @(negedge clock);
      if (ready || busy) stray++;
    end
    tests++;
    if (stray !== 0) begin
      fails++;
      $display("FAIL abort_no_ready: %0d busy/ready samples after abort, want 0", stray);
    end
    do_req(32'h0100_0001, 3'd3, 1'b0, lat);
    tests++;
    if (lat !== exp_lat(7) || result !== 32'h4B80_0001 || flags !== 5'h01) begin
      fails++;
      $display("FAIL abort_next_req: lat=%0d result=%h flags=%h, want %0d 4b800001 01", lat, result, flags, exp_lat(7));
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_zero();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
